// File: rtl/toggle_debouncer.sv
// Synchronizes and debounces a raw button, emitting one registered t pulse per
// accepted press plus a debounced level, wrapping press count and shadow T-FF state.
module toggle_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       t,
  output logic       btn_level,
  output logic [7:0] press_count,
  output logic       tq
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // A one-sample qualification window skips both wait states entirely.
  localparam bit ONE_SHOT = (DEBOUNCE_CYCLES == 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_sync;
  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   accept;
  logic                   level_nxt;

  assign btn_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      t           <= 1'b0;
      btn_level   <= 1'b0;
      press_count <= 8'd0;
      tq          <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      t           <= accept;
      btn_level   <= level_nxt;
      press_count <= accept ? press_count + 8'd1 : press_count;
      tq          <= tq ^ accept;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    level_nxt = btn_level;
    case (state)
      IDLE: begin
        if (btn_sync) begin
          if (ONE_SHOT) begin
            state_nxt = PRESSED;
            accept    = 1'b1;
          end else begin
            state_nxt = PRESS_WAIT;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          accept    = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!btn_sync) begin
          if (ONE_SHOT) begin
            state_nxt = IDLE;
            level_nxt = 1'b0;
          end else begin
            state_nxt = RELEASE_WAIT;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      RELEASE_WAIT: begin
        // A bounce back high re-enters PRESSED silently; only presses toggle.
        if (btn_sync) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          level_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    if (accept) level_nxt = 1'b1;
  end

endmodule

// File: tb/tb_toggle_debouncer.sv
// Scoreboard bench: tasks push expected t pulses (cycle, count, tq); a negedge
// monitor pops and compares them whenever t is seen high.
module tb_toggle_debouncer;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_in;
  logic       t;
  logic       btn_level;
  logic [7:0] press_count;
  logic       tq;

  toggle_debouncer dut (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .t(t), .btn_level(btn_level), .press_count(press_count), .tq(tq)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; logic [7:0] cnt; logic tq;} exp_t;
  exp_t sb[$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic       exp_tq  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pop side of the scoreboard: every observed t must match a pending entry.
  always @(negedge clk) begin
    if (t === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_t cyc=%0d press_count=%0d tq=%0b", cyc, press_count, tq);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (cyc !== e.cyc || press_count !== e.cnt || tq !== e.tq || btn_level !== 1'b1) begin
          failures++;
          $display("FAIL t_pulse got cyc=%0d cnt=%0d tq=%0b lvl=%0b want cyc=%0d cnt=%0d tq=%0b lvl=1",
                   cyc, press_count, tq, btn_level, e.cyc, e.cnt, e.tq);
        end
      end
    end
  end

  // Drive btn_in for n cycles; always entered and left on a negedge.
  task automatic hold(input logic b, input int n);
    btn_in = b;
    repeat (n) @(negedge clk);
  endtask

  // Expect an accepted press: t visible at the negedge with cycle number c.
  task automatic expect_press(input int c);
    exp_t e;
    exp_cnt = exp_cnt + 8'd1;
    exp_tq  = ~exp_tq;
    e.cyc = c; e.cnt = exp_cnt; e.tq = exp_tq;
    sb.push_back(e);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    btn_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({t, btn_level, press_count, tq} !== 11'd0) begin
        failures++;
        $display("FAIL reset_hold got t=%0b lvl=%0b cnt=%0d tq=%0b want all 0", t, btn_level, press_count, tq);
      end
    end
    rst = 1'b1;
    expect_press(cyc + 6);
    hold(1'b1, 12);
    checks++;
    if (sb.size() != 0 || press_count !== 8'd1 || tq !== 1'b1 || btn_level !== 1'b1) begin
      failures++;
      $display("FAIL reset_release got pending=%0d cnt=%0d tq=%0b lvl=%0b want 0/1/1/1",
               sb.size(), press_count, tq, btn_level);
    end
    hold(1'b0, 12);
    checks++;
    if (btn_level !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_level got %0b want 0", btn_level);
    end
  endtask

  task automatic test_glitch;
    btn_in = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 2) btn_in = 1'b0;
      checks++;
      if (btn_level !== 1'b0 || press_count !== exp_cnt) begin
        failures++;
        $display("FAIL glitch i=%0d got lvl=%0b cnt=%0d want 0/%0d", i, btn_level, press_count, exp_cnt);
      end
    end
  endtask

  task automatic test_press_bounce;
    int c;
    c = cyc;
    expect_press(c + 9);
    hold(1'b1, 2);
    hold(1'b0, 1);
    hold(1'b1, 10);
    checks++;
    if (sb.size() != 0 || press_count !== exp_cnt) begin
      failures++;
      $display("FAIL press_bounce got pending=%0d cnt=%0d want 0/%0d", sb.size(), press_count, exp_cnt);
    end
  endtask

  task automatic test_release_bounce;
    int d;
    d = cyc;
    btn_in = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      btn_in = (i == 2);
      checks++;
      if (btn_level !== (cyc < d + 9) || press_count !== exp_cnt) begin
        failures++;
        $display("FAIL release_bounce cyc=%0d got lvl=%0b cnt=%0d want %0b/%0d",
                 cyc, btn_level, press_count, (cyc < d + 9), exp_cnt);
      end
    end
  endtask

  task automatic test_wrap;
    rst = 1'b0;
    btn_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = 8'd0;
    exp_tq  = 1'b0;
    sb.delete();
    hold(1'b0, 4);
    for (int p = 1; p <= 257; p++) begin
      expect_press(cyc + 6);
      hold(1'b1, 12);
      hold(1'b0, 12);
      if (p == 256) begin
        checks++;
        if (press_count !== 8'd0 || tq !== 1'b0) begin
          failures++;
          $display("FAIL wrap_256 got cnt=%0d tq=%0b want 0/0", press_count, tq);
        end
      end
    end
    checks++;
    if (sb.size() != 0 || press_count !== 8'd1 || tq !== 1'b1) begin
      failures++;
      $display("FAIL wrap_257 got pending=%0d cnt=%0d tq=%0b want 0/1/1", sb.size(), press_count, tq);
    end
  endtask

  task automatic test_mid_reset;
    btn_in = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = 8'd0;
    exp_tq  = 1'b0;
    checks++;
    if ({t, btn_level, press_count, tq} !== 11'd0) begin
      failures++;
      $display("FAIL mid_reset got t=%0b lvl=%0b cnt=%0d tq=%0b want all 0", t, btn_level, press_count, tq);
    end
    expect_press(cyc + 6);
    hold(1'b1, 12);
    checks++;
    if (sb.size() != 0 || press_count !== 8'd1 || tq !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_press got pending=%0d cnt=%0d tq=%0b want 0/1/1", sb.size(), press_count, tq);
    end
    hold(1'b0, 12);
  endtask

  initial begin
    test_reset;
    test_glitch;
    test_press_bounce;
    test_release_bounce;
    test_wrap;
    test_mid_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
